// File: rtl/machine_dump_sequencer.sv
// Result-dump stage behind the single-cycle machine: traces executed PCs through a
// small FIFO, detects end of run, then streams registers and a memory window.
module machine_dump_sequencer #(
  parameter int unsigned MAX_CYCLES = 64,
  parameter int unsigned NUM_REGS   = 32,
  parameter logic [31:0] MEM_BASE   = 32'h4000,
  parameter int unsigned MEM_WORDS  = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [29:0] pc_word,
  input  logic [31:0] inst,
  output logic        machine_stall,
  output logic [4:0]  rf_addr,
  input  logic [31:0] rf_data,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [1:0]  out_kind,
  output logic        out_last,
  output logic        done
);

  localparam int unsigned PW      = $clog2(FIFO_DEPTH);
  localparam int unsigned CW      = $clog2(MAX_CYCLES + 1);
  localparam int unsigned IDX_MAX = (NUM_REGS > MEM_WORDS) ? NUM_REGS : MEM_WORDS;
  localparam int unsigned IW      = $clog2(IDX_MAX);

  typedef enum logic [2:0] {
    S_IDLE, S_TRACE, S_DRAIN, S_REGS, S_MEM, S_DONE
  } state_e;

  typedef enum logic [1:0] {
    KIND_PC  = 2'd0,
    KIND_REG = 2'd1,
    KIND_MEM = 2'd2
  } kind_e;

  state_e          state;
  kind_e           kind_q;
  logic            last_q;
  logic            done_q;
  logic            dump_stall;
  logic [CW-1:0]   cycle_cnt;
  logic [IW-1:0]   idx;

  logic [31:0]     fifo_mem [FIFO_DEPTH];
  logic [PW:0]     wr_ptr;
  logic [PW:0]     rd_ptr;
  logic            fifo_empty;
  logic            fifo_full;
  logic            pc_phase;
  logic            trace_push;
  logic            handshake;
  logic            pc_pop;

  // Extra pointer bit distinguishes full from empty when the low bits match.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

  assign pc_phase   = (state == S_TRACE) || (state == S_DRAIN);
  assign trace_push = (state == S_TRACE) && run && !fifo_full;
  assign out_valid  = pc_phase ? !fifo_empty : ((state == S_REGS) || (state == S_MEM));
  assign handshake  = out_valid && out_ready;
  assign pc_pop     = pc_phase && handshake;

  assign machine_stall = dump_stall || ((state == S_TRACE) && fifo_full);
  assign rf_addr       = 5'(idx);
  assign mem_addr      = (state == S_MEM) ? (MEM_BASE + 32'(idx)) : MEM_BASE;
  assign out_kind      = kind_q;
  assign out_last      = last_q;
  assign done          = done_q;

  // NOTE: trace storage carries no reset; the head is only presented while non-empty.
  always_ff @(posedge clk) begin
    if (trace_push) fifo_mem[wr_ptr[PW-1:0]] <= {pc_word, 2'b00};
  end

  always_comb begin
    out_data = '0; // NOTE: default first so no path leaves out_data unassigned (no latch)
    case (state)
      S_TRACE, S_DRAIN: if (!fifo_empty) out_data = fifo_mem[rd_ptr[PW-1:0]];
      S_REGS:           out_data = rf_data;
      S_MEM:            out_data = mem_data;
      default:          out_data = '0;
    endcase
  end

  // NOTE: all state updates use <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      kind_q     <= KIND_PC;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
      dump_stall <= 1'b0;
      cycle_cnt  <= '0;
      idx        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      if (trace_push) wr_ptr <= wr_ptr + 1'b1;
      if (pc_pop)     rd_ptr <= rd_ptr + 1'b1;

      case (state)
        S_IDLE: begin
          if (run) state <= S_TRACE;
        end
        S_TRACE: begin
          if (trace_push) begin
            cycle_cnt <= cycle_cnt + 1'b1;
            if ((inst == 32'h0) || (cycle_cnt == CW'(MAX_CYCLES - 1))) begin
              state      <= S_DRAIN;
              dump_stall <= 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (fifo_empty) begin
            state  <= S_REGS;
            kind_q <= KIND_REG;
          end
        end
        S_REGS: begin
          if (handshake) begin
            if (idx == IW'(NUM_REGS - 1)) begin
              idx    <= '0;
              state  <= S_MEM;
              kind_q <= KIND_MEM;
              last_q <= (MEM_WORDS == 1);
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        S_MEM: begin
          if (handshake) begin
            if (idx == IW'(MEM_WORDS - 1)) begin
              state  <= S_DONE;
              done_q <= 1'b1;
              last_q <= 1'b0;
            end else begin
              idx    <= idx + 1'b1;
              last_q <= (idx == IW'(MEM_WORDS - 2));
            end
          end
        end
        default: ; // S_DONE holds until reset
      endcase
    end
  end

endmodule

// File: tb/tb_machine_dump_sequencer.sv
// Randomized bench for machine_dump_sequencer: a stream-level reference model
// (expected word list plus FIFO occupancy count) is compared against the DUT every cycle.
`timescale 1ns/1ps
module tb_machine_dump_sequencer;

  localparam int MAX_CYCLES = 64;
  localparam int FIFO_DEPTH = 4;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] data;
    logic        last;
  } word_t;

  logic        clk;
  logic        reset;
  logic        run;
  logic [29:0] pc_word;
  logic [31:0] inst;
  logic        machine_stall;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_kind;
  logic        out_last;
  logic        done;

  logic [31:0] rf_model  [32];
  logic [31:0] mem_model [4];
  logic [29:0] pcs   [MAX_CYCLES + 1];
  logic [31:0] insts [MAX_CYCLES + 1];

  int n_cmp = 0;
  int n_err = 0;

  machine_dump_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .run          (run),
    .pc_word      (pc_word),
    .inst         (inst),
    .machine_stall(machine_stall),
    .rf_addr      (rf_addr),
    .rf_data      (rf_data),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_kind     (out_kind),
    .out_last     (out_last),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational register file and data memory seen by the dump stage.
  always_comb begin
    logic [31:0] off;
    rf_data = rf_model[rf_addr];
    off     = mem_addr - 32'h4000;
    if (mem_addr >= 32'h4000 && mem_addr < 32'h4004) mem_data = mem_model[off[1:0]];
    else                                              mem_data = 32'hBAD0_0000 | {16'h0, mem_addr[15:0]};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_valid"},    32'(out_valid),     0);
    check({tag, "_data"},     out_data,           0);
    check({tag, "_kind"},     32'(out_kind),      0);
    check({tag, "_last"},     32'(out_last),      0);
    check({tag, "_done"},     32'(done),          0);
    check({tag, "_stall"},    32'(machine_stall), 0);
    check({tag, "_rf_addr"},  32'(rf_addr),       0);
    check({tag, "_mem_addr"}, mem_addr,           32'h4000);
  endtask

  // mode: 0 ready always, 1 random, 2 ten-cycle backpressure in TRACE, 3 random only in REGS
  task automatic run_session(input int mode, input int halt_at, input bit seq,
                             input int abort_reg, input int exp_size);
    word_t       exp_q[$];
    int          halt_idx, k, pushes, pops, nwords, occ, cyc;
    bit          halted, hs, prev_v, prev_r;
    logic [31:0] prev_d;
    logic [1:0]  prev_k;
    logic        prev_l;

    for (int i = 0; i <= MAX_CYCLES; i++) begin
      pcs[i]   = seq ? (30'h0010_0000 + 30'(i)) : 30'($urandom);
      insts[i] = $urandom | 32'h1;
    end
    if (halt_at >= 0) insts[halt_at] = 32'h0;
    for (int i = 0; i < 32; i++) rf_model[i] = $urandom;
    rf_model[0] = 32'h0;
    rf_model[2] = 32'h0040_0022;
    for (int i = 0; i < 4; i++) mem_model[i] = $urandom;

    halt_idx = MAX_CYCLES - 1;
    for (int i = MAX_CYCLES - 1; i >= 0; i--) if (insts[i] == 32'h0) halt_idx = i;

    for (int i = 0; i <= halt_idx; i++) exp_q.push_back('{2'd0, {pcs[i], 2'b00}, 1'b0});
    for (int i = 0; i < 32; i++)        exp_q.push_back('{2'd1, rf_model[i], 1'b0});
    for (int i = 0; i < 4; i++)         exp_q.push_back('{2'd2, mem_model[i], i == 3});

    check("model_size", exp_q.size(), exp_size);
    if (seq) begin
      check("pin_pc0", exp_q[0].data, 32'h0040_0000);
      check("pin_pc2", exp_q[2].data, 32'h0040_0008);
      check("pin_r2",  exp_q[halt_idx + 3].data, 32'h0040_0022);
    end
    if (halt_at == 0) begin
      check("pin_last_flag", 32'(exp_q[36].last), 1);
      check("pin_last_kind", 32'(exp_q[36].kind), 2);
    end

    @(posedge clk);
    #1 reset = 1'b0; run = 1'b0; out_ready = 1'b0;
    #1 check_reset("reset");
    @(posedge clk);
    #1 reset = 1'b1; run = 1'b1; pc_word = pcs[0]; inst = insts[0];
    #1 check("idle_stall", 32'(machine_stall), 0);
    check("idle_valid", 32'(out_valid), 0);
    @(posedge clk);

    k = 0; pushes = 0; pops = 0; nwords = 0; cyc = 0;
    halted = 0; prev_v = 0; prev_r = 0; prev_d = '0; prev_k = '0; prev_l = 0;

    while (nwords < exp_q.size() && cyc < 1500) begin
      #1;
      pc_word = pcs[k];
      inst    = insts[k];
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 2) != 0);
        2:       out_ready = (cyc >= 10);
        default: out_ready = (nwords >= halt_idx + 1 && nwords < halt_idx + 33)
                             ? ($urandom_range(0, 1) == 1) : 1'b1;
      endcase
      #1;
      occ = pushes - pops;
      check("stall", 32'(machine_stall), 32'(halted || occ == FIFO_DEPTH));
      check("done_early", 32'(done), 0);
      if (occ > 0) begin
        check("pc_valid", 32'(out_valid), 1);
        check("pc_kind",  32'(out_kind),  0);
        check("pc_head",  out_data, {pcs[pops], 2'b00});
      end
      if (prev_v && !prev_r) begin
        check("hold_valid", 32'(out_valid), 1);
        check("hold_data",  out_data,       prev_d);
        check("hold_kind",  32'(out_kind),  32'(prev_k));
        check("hold_last",  32'(out_last),  32'(prev_l));
      end
      if (mode == 2 && cyc == 9) check("bp_full_stall", 32'(machine_stall), 1);

      hs = out_valid && out_ready;
      if (hs) begin
        check("word_kind", 32'(out_kind), 32'(exp_q[nwords].kind));
        check("word_data", out_data,      exp_q[nwords].data);
        check("word_last", 32'(out_last), 32'(exp_q[nwords].last));
        if (exp_q[nwords].kind == 2'd0) pops++;
        nwords++;
      end
      if (!halted && occ < FIFO_DEPTH) begin
        if (pushes == halt_idx) halted = 1;
        pushes++;
      end
      if (!machine_stall && k < MAX_CYCLES) k++;
      prev_v = out_valid; prev_r = out_ready;
      prev_d = out_data;  prev_k = out_kind; prev_l = out_last;

      @(posedge clk);
      cyc++;
      if (abort_reg >= 0 && nwords == halt_idx + 1 + abort_reg) begin
        #1 check("abort_rf_addr", 32'(rf_addr), 32'(abort_reg));
        reset = 1'b0;
        #1 check_reset("abort");
        return;
      end
    end

    check("stream_count", 32'(nwords), 32'(exp_q.size()));
    #2;
    check("end_done",  32'(done),          1);
    check("end_valid", 32'(out_valid),     0);
    check("end_stall", 32'(machine_stall), 1);
  endtask

  initial begin
    reset     = 1'b0;
    run       = 1'b0;
    out_ready = 1'b0;
    pc_word   = '0;
    inst      = '0;
    for (int i = 0; i < 32; i++) rf_model[i] = '0;
    for (int i = 0; i < 4; i++)  mem_model[i] = '0;
    repeat (2) @(posedge clk);

    run_session(0,  2, 1'b1, -1, 39);   // halt on zero instruction
    run_session(1, -1, 1'b0, -1, 100);  // cycle budget exhausted
    run_session(2, 20, 1'b0, -1, 57);   // backpressure during trace
    run_session(3,  5, 1'b0, -1, 42);   // random ready during register dump
    run_session(0,  3, 1'b0, 10, 40);   // async reset in the middle of the register dump
    run_session(1,  0, 1'b0, -1, 37);   // immediate halt after a fresh restart

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/machine_dump_sequencer.md
Name: machine_dump_sequencer

Overview:
- Synthesizable result-dump stage sitting directly downstream of the single-cycle `machine`.
- Each executed cycle it captures the byte PC into a small trace FIFO.
- It detects end of run: an all-zero instruction word or a cycle budget exhausted.
- On end of run it stalls the machine, then serially streams all registers and a data-memory window over a valid/ready port to the autograder host interface.

Parameters:
- MAX_CYCLES, 64: cycle budget; halt when this many PCs have been traced.
- NUM_REGS, 32: register-file entries dumped, indices 0..NUM_REGS-1.
- MEM_BASE, 32'h4000: first data_seg word index dumped.
- MEM_WORDS, 4: number of data_seg words dumped.
- FIFO_DEPTH, 4: PC trace FIFO entries, power of two.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- run  in  1  machine out of reset and executing.
- pc_word  in  30  machine PC register q (word address).
- inst  in  32  instruction currently fetched.
- machine_stall  out  1  freezes PC/RF/memory writes when high.
- rf_addr  out  5  register-file read index.
- rf_data  in  32  combinational read data for rf_addr.
- mem_addr  out  32  data_seg word index.
- mem_data  in  32  combinational read data for mem_addr.
- out_valid  out  1  stream word valid.
- out_ready  in  1  sink accepts word.
- out_data  out  32  stream payload.
- out_kind  out  2  0 = PC, 1 = REG, 2 = MEM.
- out_last  out  1  final word of the dump.
- done  out  1  dump complete, sticky.

Behaviour:
- Reset (reset=0, async), all of the following:
  - State goes to IDLE; FIFO is emptied; cycle count = 0.
  - Outputs: machine_stall=0, out_valid=0, out_data=0, out_kind=0, out_last=0, done=0, rf_addr=0, mem_addr=MEM_BASE.
  - Reset mid-dump aborts immediately; no partial-word hold is required.
- States: IDLE -> TRACE -> DRAIN -> REGS -> MEM -> DONE.
- IDLE: go to TRACE on the first rising edge with run=1. Nothing is pushed in IDLE.
- TRACE, each rising edge with run=1 and FIFO not full:
  - Push {pc_word,2'b00}.
  - cycle count +1.
  - Halt condition: inst==32'h0 OR count+1==MAX_CYCLES.
  - On halt, go to DRAIN. The halting cycle's PC is still pushed.
- TRACE with FIFO full:
  - machine_stall=1 combinationally.
  - No push, no count.
  - Halt is not evaluated.
- machine_stall=1 in every state from DRAIN through DONE, and in TRACE when FIFO is full.
- Stream port, PC words:
  - FIFO head is presented with out_kind=0 whenever the FIFO is non-empty (TRACE or DRAIN).
  - Pop on out_valid&&out_ready. Push and pop in the same cycle are both honoured; full/empty flags stay consistent.
  - Stream FIFO latency: a word pushed at edge N is visible on out_data after edge N.
- DRAIN: go to REGS when the FIFO is empty (registered check, one idle cycle allowed).
- REGS:
  - rf_addr = idx; out_data = rf_data; out_kind=1; out_valid=1.
  - idx advances on handshake.
  - After index NUM_REGS-1 is accepted, go to MEM with idx=0.
- MEM:
  - mem_addr = MEM_BASE+idx; out_data = mem_data; out_kind=2.
  - out_last=1 on idx==MEM_WORDS-1.
  - That handshake goes to DONE.
- DONE: out_valid=0, done=1, machine_stall=1. Hold until reset.
- Handshake rules:
  - While out_valid=1 and out_ready=0, out_data, out_kind and out_last must not change.
  - Holds because indices only move on handshake and the machine is stalled.
- Simultaneous inst==0 on the very first TRACE cycle: that PC is pushed, then DRAIN; exactly one PC word is output.
- Register r0 is dumped as read (expected 0). No special-casing.

Test Plan:
- Halt on zero instruction:
  - Stimulus: run=1 with PCs 0x00400000, 0x00400004, 0x00400008; inst=0 on the third; out_ready=1.
  - Required: PC words 0x00400000, 0x00400004, 0x00400008; then 32 REG words equal to the RF model; then 4 MEM words for 0x4000..0x4003 with out_last on the 4th; done=1.
- Budget exhaustion:
  - Stimulus: inst never 0, MAX_CYCLES=64.
  - Required: exactly 64 PC words, then the dump. machine_stall rises the edge after the 64th push.
- Backpressure:
  - Stimulus: out_ready=0 for 10 cycles during TRACE.
  - Required: FIFO fills at 4 entries and machine_stall=1. The PC sequence resumes with no loss or duplication; the held word stays stable while stalled.
- Random out_ready during REGS with r2=32'h00400022.
  - Required: word index 2 = 0x00400022, stable across stalls; all indices output in order, none skipped.
- Async reset mid-REGS (reset low at index 10):
  - Required: all outputs return to reset values immediately.
  - After release and run=1, the sequence restarts with a fresh PC trace.
- Immediate halt (inst=0 on first TRACE cycle):
  - Required: one PC word, then 36 dump words; the last carries out_last=1 and out_kind=2.
